// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: FSM encoding, default widths and
// the register-zero constant that never receives a writeback.
package mips_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int REG_AW_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

endpackage

// File: rtl/wb_result_reg.sv
// W pipeline register: one-cycle write-enable pulse per retiring writer,
// address and data only reload when a write actually happens.
module wb_result_reg #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              reg_write_W,
  output logic [REG_AW-1:0] A3_W,
  output logic [WIDTH-1:0]  WD3_W
);

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_W <= 1'b0;
      A3_W        <= '0;
      WD3_W       <= '0;
    end else begin
      reg_write_W <= wb_en;
      if (wb_en) begin
        A3_W  <= wb_addr;
        WD3_W <= wb_data;
      end
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: drives a variable-latency data-memory
// handshake with a timeout, stalls upstream while waiting, feeds the W register.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_M,
  input  logic [WIDTH-1:0]  ALU_out_M,
  input  logic [WIDTH-1:0]  write_data_M,
  input  logic [REG_AW-1:0] write_reg_M,
  input  logic              reg_write_M,
  input  logic              mem_to_reg_M,
  input  logic              mem_write_M,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              stall_M,
  output logic              reg_write_W,
  output logic [REG_AW-1:0] A3_W,
  output logic [WIDTH-1:0]  WD3_W,
  output logic              mem_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [REG_AW-1:0] R0   = REG_AW'(REG_ZERO);

  mem_state_t        state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [WIDTH-1:0]  addr_reg, addr_next;
  logic [WIDTH-1:0]  wdata_reg, wdata_next;
  logic [REG_AW-1:0] wreg_reg, wreg_next;
  logic              rw_reg, rw_next;
  logic              err_reg, err_next;

  logic              mem_op;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;

  assign mem_op = valid_M & (mem_to_reg_M | mem_write_M);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wreg_next  = wreg_reg;
    rw_next    = rw_reg;
    err_next   = err_reg;
    stall_M    = 1'b0;
    wb_en      = 1'b0;
    wb_addr    = write_reg_M;
    wb_data    = ALU_out_M;
    case (state_reg)
      IDLE: begin
        if (mem_op) begin
          stall_M    = 1'b1;
          state_next = ACCESS;
          cnt_next   = '0;
          req_next   = 1'b1;
          we_next    = mem_write_M;
          addr_next  = ALU_out_M;
          wdata_next = write_data_M;
          wreg_next  = write_reg_M;
          rw_next    = reg_write_M;
        end else begin
          wb_en = valid_M & reg_write_M & (write_reg_M != R0);
        end
      end
      ACCESS: begin
        // M-stage inputs are ignored here: upstream is holding the same op.
        stall_M = ~mem_ack & (cnt_reg != CNT_LAST);
        wb_addr = wreg_reg;
        wb_data = mem_rdata;
        if (mem_ack) begin
          state_next = IDLE;
          req_next   = 1'b0;
          wb_en      = ~we_reg & rw_reg & (wreg_reg != R0);
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          req_next   = 1'b0;
          err_next   = 1'b1;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wreg_reg  <= '0;
      rw_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wreg_reg  <= wreg_next;
      rw_reg    <= rw_next;
      err_reg   <= err_next;
    end
  end

  assign mem_req   = req_reg;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_err   = err_reg;

  wb_result_reg #(
    .WIDTH  (WIDTH),
    .REG_AW (REG_AW)
  ) u_wb_result_reg (
    .clk         (clk),
    .reset       (reset),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .reg_write_W (reg_write_W),
    .A3_W        (A3_W),
    .WD3_W       (WD3_W)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: one task per scenario.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_M;
  logic [31:0] ALU_out_M;
  logic [31:0] write_data_M;
  logic [4:0]  write_reg_M;
  logic        reg_write_M;
  logic        mem_to_reg_M;
  logic        mem_write_M;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall_M;
  logic        reg_write_W;
  logic [4:0]  A3_W;
  logic [31:0] WD3_W;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.WIDTH(32), .REG_AW(5), .TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_M      (valid_M),
    .ALU_out_M    (ALU_out_M),
    .write_data_M (write_data_M),
    .write_reg_M  (write_reg_M),
    .reg_write_M  (reg_write_M),
    .mem_to_reg_M (mem_to_reg_M),
    .mem_write_M  (mem_write_M),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .stall_M      (stall_M),
    .reg_write_W  (reg_write_W),
    .A3_W         (A3_W),
    .WD3_W        (WD3_W),
    .mem_err      (mem_err)
  );

  task automatic clear_inputs();
    valid_M = 0; ALU_out_M = 0; write_data_M = 0; write_reg_M = 0;
    reg_write_M = 0; mem_to_reg_M = 0; mem_write_M = 0;
    mem_rdata = 0; mem_ack = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    #1;
    checks++;
    if ({mem_req, mem_we, stall_M, reg_write_W, mem_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000", {mem_req, mem_we, stall_M, reg_write_W, mem_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, WD3_W, A3_W} !== 101'b0) begin
      errors++; $display("FAIL reset_data got addr=%h wdata=%h wd3=%h a3=%h want all 0", mem_addr, mem_wdata, WD3_W, A3_W);
    end
    $display("reset: done");
  endtask

  task automatic test_rtype();
    valid_M = 1; reg_write_M = 1; write_reg_M = 8; ALU_out_M = 32'h10;
    #1;
    checks++;
    if (stall_M !== 1'b0) begin errors++; $display("FAIL rtype_stall got %b want 0", stall_M); end
    step();
    checks++;
    if (reg_write_W !== 1'b1 || A3_W !== 5'd8 || WD3_W !== 32'h10) begin
      errors++; $display("FAIL rtype_wb got we=%b a3=%0d wd3=%h want we=1 a3=8 wd3=00000010", reg_write_W, A3_W, WD3_W);
    end
    clear_inputs();
    step();
    checks++;
    if (reg_write_W !== 1'b0 || A3_W !== 5'd8 || WD3_W !== 32'h10) begin
      errors++; $display("FAIL rtype_pulse got we=%b a3=%0d wd3=%h want we=0 a3=8 wd3=00000010", reg_write_W, A3_W, WD3_W);
    end
    $display("rtype: r8 <= 0x10");
  endtask

  task automatic test_load();
    valid_M = 1; mem_to_reg_M = 1; reg_write_M = 1; write_reg_M = 9; ALU_out_M = 32'h100;
    #1;
    checks++;
    if (stall_M !== 1'b1) begin errors++; $display("FAIL load_accept_stall got %b want 1", stall_M); end
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; #1; end
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
        errors++; $display("FAIL load_req_c%0d got req=%b addr=%h we=%b want req=1 addr=00000100 we=0", c, mem_req, mem_addr, mem_we);
      end
      checks++;
      if (stall_M !== (c < 3)) begin errors++; $display("FAIL load_stall_c%0d got %b want %b", c, stall_M, (c < 3)); end
      checks++;
      if (reg_write_W !== 1'b0) begin errors++; $display("FAIL load_early_wb_c%0d got %b want 0", c, reg_write_W); end
    end
    step();
    clear_inputs();
    checks++;
    if (reg_write_W !== 1'b1 || A3_W !== 5'd9 || WD3_W !== 32'hDEADBEEF || mem_req !== 1'b0) begin
      errors++; $display("FAIL load_wb got we=%b a3=%0d wd3=%h req=%b want we=1 a3=9 wd3=deadbeef req=0", reg_write_W, A3_W, WD3_W, mem_req);
    end
    $display("load: r9 <= mem[0x100] = 0x%h", WD3_W);
  endtask

  task automatic test_store();
    valid_M = 1; mem_write_M = 1; ALU_out_M = 32'h200; write_data_M = 32'h55;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h55) begin
      errors++; $display("FAIL store_req got req=%b we=%b addr=%h wdata=%h want 1 1 00000200 00000055", mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1;
    step();
    clear_inputs();
    checks++;
    if (reg_write_W !== 1'b0 || mem_req !== 1'b0 || WD3_W !== 32'hDEADBEEF || A3_W !== 5'd9) begin
      errors++; $display("FAIL store_wb got we=%b req=%b wd3=%h a3=%0d want we=0 req=0 wd3=deadbeef a3=9", reg_write_W, mem_req, WD3_W, A3_W);
    end
    $display("store: mem[0x200] <= 0x55");
  endtask

  task automatic test_r0();
    valid_M = 1; reg_write_M = 1; write_reg_M = 0; ALU_out_M = 32'h77;
    step();
    clear_inputs();
    checks++;
    if (reg_write_W !== 1'b0 || WD3_W !== 32'hDEADBEEF) begin
      errors++; $display("FAIL r0_write got we=%b wd3=%h want we=0 wd3=deadbeef", reg_write_W, WD3_W);
    end
    $display("r0: write suppressed");
  endtask

  task automatic test_timeout();
    valid_M = 1; mem_to_reg_M = 1; reg_write_M = 1; write_reg_M = 10; ALU_out_M = 32'h300;
    for (int c = 1; c <= 15; c++) begin
      step();
      checks++;
      if (mem_req !== 1'b1 || stall_M !== (c < 15)) begin
        errors++; $display("FAIL timeout_c%0d got req=%b stall=%b want req=1 stall=%b", c, mem_req, stall_M, (c < 15));
      end
    end
    step();
    clear_inputs();
    checks++;
    if (mem_req !== 1'b0 || mem_err !== 1'b1 || reg_write_W !== 1'b0) begin
      errors++; $display("FAIL timeout_end got req=%b err=%b we=%b want req=0 err=1 we=0", mem_req, mem_err, reg_write_W);
    end
    valid_M = 1; reg_write_M = 1; write_reg_M = 3; ALU_out_M = 32'h33;
    step();
    clear_inputs();
    checks++;
    if (reg_write_W !== 1'b1 || A3_W !== 5'd3 || WD3_W !== 32'h33 || mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_next got we=%b a3=%0d wd3=%h err=%b want 1 3 00000033 1", reg_write_W, A3_W, WD3_W, mem_err);
    end
    mem_ack = 1; mem_rdata = 32'hCAFE;
    step();
    mem_ack = 0;
    checks++;
    if (mem_req !== 1'b0 || reg_write_W !== 1'b0 || mem_err !== 1'b1 || WD3_W !== 32'h33) begin
      errors++; $display("FAIL idle_ack got req=%b we=%b err=%b wd3=%h want 0 0 1 00000033", mem_req, reg_write_W, mem_err, WD3_W);
    end
    $display("timeout: mem_err=%b", mem_err);
  endtask

  task automatic test_reset_in_access();
    valid_M = 1; mem_to_reg_M = 1; reg_write_M = 1; write_reg_M = 11; ALU_out_M = 32'h400;
    step(); step();
    reset = 1;
    clear_inputs();
    step();
    reset = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || reg_write_W !== 1'b0 || mem_err !== 1'b0 || stall_M !== 1'b0) begin
      errors++; $display("FAIL rst_access got req=%b we=%b err=%b stall=%b want all 0", mem_req, reg_write_W, mem_err, stall_M);
    end
    mem_ack = 1; mem_rdata = 32'hBAD;
    step();
    mem_ack = 0;
    checks++;
    if (reg_write_W !== 1'b0 || mem_req !== 1'b0 || WD3_W !== 32'h0) begin
      errors++; $display("FAIL rst_late_ack got we=%b req=%b wd3=%h want 0 0 00000000", reg_write_W, mem_req, WD3_W);
    end
    $display("reset in access: abandoned");
  endtask

  task automatic test_ack_at_limit();
    valid_M = 1; mem_to_reg_M = 1; reg_write_M = 1; write_reg_M = 12; ALU_out_M = 32'h500;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (c == 15) begin mem_ack = 1; mem_rdata = 32'h1234; #1; end
    end
    checks++;
    if (stall_M !== 1'b0 || mem_req !== 1'b1) begin
      errors++; $display("FAIL limit_ack_cycle got stall=%b req=%b want 0 1", stall_M, mem_req);
    end
    step();
    clear_inputs();
    checks++;
    if (reg_write_W !== 1'b1 || A3_W !== 5'd12 || WD3_W !== 32'h1234 || mem_err !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL limit_ack_wb got we=%b a3=%0d wd3=%h err=%b req=%b want 1 12 00001234 0 0", reg_write_W, A3_W, WD3_W, mem_err, mem_req);
    end
    $display("ack at limit: r12 <= 0x%h", WD3_W);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_r0();
    test_timeout();
    test_reset_in_access();
    test_ack_at_limit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
